// File: rtl/l1_avalon_bridge_pkg.sv
// Shared types and constants for the L1-to-Avalon bridge.
package l1_avalon_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_RESP
    } l1_bridge_state_t;

    localparam int L1_BRIDGE_MAX_BURST = 8;

    // Word address plus beat offset, wrapping within the 32-bit byte space.
    function automatic logic [31:0] beatAddr(input logic [29:0] word, input logic [29:0] beat);
        logic [29:0] sum;
        sum = word + beat;
        return {sum, 2'b00};
    endfunction

endpackage

// File: rtl/l1_avalon_bridge_if.sv
// Avalon-MM bus between the L1 bridge (master) and the external interconnect (slave).
interface l1_avalon_bridge_if;
    logic [31:0] addr;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        readdatavalid;
    logic        writeresponsevalid;

    modport master (
        output addr, read, write, byteenable, writedata,
        input  readdata, waitrequest, readdatavalid, writeresponsevalid
    );

    modport slave (
        input  addr, read, write, byteenable, writedata,
        output readdata, waitrequest, readdatavalid, writeresponsevalid
    );
endinterface

// File: rtl/l1_avalon_bridge.sv
// Turns one arbitrated L1 request into single-word Avalon-MM transactions,
// one outstanding at a time, returning each read word on the L1 return path.
module l1_avalon_bridge
    import l1_avalon_bridge_pkg::*;
#(
    parameter bit WAIT_WRITE_RESP = 1'b1,
    parameter int MAX_BURST       = L1_BRIDGE_MAX_BURST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] l1_addr_i,
    input  logic [31:0] l1_data_i,
    input  logic        l1_rnw_i,
    input  logic [0:3]  l1_be_i,
    input  logic [2:0]  l1_size_i,
    input  logic        l1_is_amo_i,
    input  logic [4:0]  l1_amo_i,
    input  logic        l1_request_i,
    output logic        l1_ack_o,
    output logic [31:0] ret_data_o,
    output logic        ret_data_valid_o,
    output logic [29:0] ret_inv_addr_o,
    output logic        ret_inv_valid_o,
    input  logic        ret_inv_ack_i,
    l1_avalon_bridge_if.master av
);

    localparam int BEAT_W = $clog2(MAX_BURST);

    l1_bridge_state_t  state_q;
    logic [29:0]       addr_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] size_q;
    logic [31:0]       avAddr_q;
    logic              avRead_q;
    logic              avWrite_q;
    logic [3:0]        avBe_q;
    logic [31:0]       avWdata_q;
    logic [31:0]       retData_q;
    logic              retValid_q;
    logic [3:0]        beMapped;
    logic              unusedInputs;

    assign l1_ack_o = rst_n && (state_q == IDLE) && l1_request_i;

    // The L1 side numbers byte enables [0:3]; the bus numbers them [3:0] with the same index meaning.
    always_comb begin
        beMapped = '0;
        for (int i = 0; i < 4; i++) begin
            beMapped[i] = l1_be_i[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            beat_q     <= '0;
            size_q     <= '0;
            avAddr_q   <= '0;
            avRead_q   <= 1'b0;
            avWrite_q  <= 1'b0;
            avBe_q     <= '0;
            avWdata_q  <= '0;
            retData_q  <= '0;
            retValid_q <= 1'b0;
        end else begin
            retValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (l1_request_i) begin
                        addr_q   <= l1_addr_i[31:2];
                        size_q   <= l1_size_i[BEAT_W-1:0];
                        beat_q   <= '0;
                        avAddr_q <= {l1_addr_i[31:2], 2'b00};
                        if (l1_rnw_i) begin
                            avRead_q <= 1'b1;
                            avBe_q   <= 4'hF;
                            state_q  <= RD_ISSUE;
                        end else begin
                            avWrite_q <= 1'b1;
                            avBe_q    <= beMapped;
                            avWdata_q <= l1_data_i;
                            state_q   <= WR_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (!av.waitrequest) begin
                        avRead_q <= 1'b0;
                        state_q  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (av.readdatavalid) begin
                        retData_q  <= av.readdata;
                        retValid_q <= 1'b1;
                        if (beat_q == size_q) begin
                            state_q <= IDLE;
                        end else begin
                            beat_q   <= beat_q + BEAT_W'(1);
                            avRead_q <= 1'b1;
                            avAddr_q <= beatAddr(addr_q, 30'(beat_q) + 30'd1);
                            state_q  <= RD_ISSUE;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (!av.waitrequest) begin
                        avWrite_q <= 1'b0;
                        state_q   <= WAIT_WRITE_RESP ? WR_RESP : IDLE;
                    end
                end
                WR_RESP: begin
                    if (av.writeresponsevalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign av.addr          = avAddr_q;
    assign av.read          = avRead_q;
    assign av.write         = avWrite_q;
    assign av.byteenable    = avBe_q;
    assign av.writedata     = avWdata_q;
    assign ret_data_o       = retData_q;
    assign ret_data_valid_o = retValid_q;
    assign ret_inv_addr_o   = '0;
    assign ret_inv_valid_o  = 1'b0;

    // AMOs are never routed here and invalidations are not generated, so these inputs are don't-care.
    assign unusedInputs = ^{l1_addr_i[1:0], l1_size_i, l1_is_amo_i, l1_amo_i, ret_inv_ack_i};

endmodule

// File: tb/tb_l1_avalon_bridge.sv
// Directed bench for l1_avalon_bridge: Avalon slave responses are driven cycle by cycle.
module tb_l1_avalon_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] l1Addr;
    logic [31:0] l1Data;
    logic        l1Rnw;
    logic [0:3]  l1Be;
    logic [2:0]  l1Size;
    logic        l1IsAmo;
    logic [4:0]  l1Amo;
    logic        l1Request;
    logic        l1Ack;
    logic [31:0] retData;
    logic        retValid;
    logic [29:0] retInvAddr;
    logic        retInvValid;
    logic        retInvAck;

    int vectors = 0;
    int miscompares = 0;
    int retCount = 0;

    l1_avalon_bridge_if av ();

    l1_avalon_bridge #(.WAIT_WRITE_RESP(1'b1), .MAX_BURST(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .l1_addr_i        (l1Addr),
        .l1_data_i        (l1Data),
        .l1_rnw_i         (l1Rnw),
        .l1_be_i          (l1Be),
        .l1_size_i        (l1Size),
        .l1_is_amo_i      (l1IsAmo),
        .l1_amo_i         (l1Amo),
        .l1_request_i     (l1Request),
        .l1_ack_o         (l1Ack),
        .ret_data_o       (retData),
        .ret_data_valid_o (retValid),
        .ret_inv_addr_o   (retInvAddr),
        .ret_inv_valid_o  (retInvValid),
        .ret_inv_ack_i    (retInvAck),
        .av               (av.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (retValid === 1'b1) retCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        l1Addr = '0; l1Data = '0; l1Rnw = 1'b0; l1Be = '0; l1Size = '0;
        l1IsAmo = 1'b0; l1Amo = '0; l1Request = 1'b0; retInvAck = 1'b0;
        av.readdata = '0; av.waitrequest = 1'b0; av.readdatavalid = 1'b0; av.writeresponsevalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearInputs();
        l1Request = 1'b1;
        tick(); tick();
        vectors++; if (l1Ack !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ack actual=%0h expected=0", l1Ack); end
        vectors++; if (av.read !== 1'b0 || av.write !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rw actual=%0h/%0h expected=0/0", av.read, av.write); end
        vectors++; if (av.addr !== 32'h0 || av.byteenable !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_addr_be actual=%h/%h expected=0/0", av.addr, av.byteenable); end
        vectors++; if (retValid !== 1'b0 || retData !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_ret actual=%0h/%h expected=0/0", retValid, retData); end
        vectors++; if (retInvValid !== 1'b0 || retInvAddr !== 30'h0) begin miscompares++; $display("[TB] FAIL rst_inv actual=%0h/%h expected=0/0", retInvValid, retInvAddr); end
        l1Request = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int startCount;
        startCount = retCount;
        l1Addr = 32'h0000_1000; l1Rnw = 1'b1; l1Size = 3'd0; l1Request = 1'b1;
        #1;
        vectors++; if (l1Ack !== 1'b1) begin miscompares++; $display("[TB] FAIL rd1_ack actual=%0h expected=1", l1Ack); end
        tick();
        l1Request = 1'b0;
        vectors++; if (av.read !== 1'b1 || av.addr !== 32'h0000_1000) begin miscompares++; $display("[TB] FAIL rd1_issue actual=%0h/%h expected=1/00001000", av.read, av.addr); end
        vectors++; if (av.byteenable !== 4'hF) begin miscompares++; $display("[TB] FAIL rd1_be actual=%h expected=f", av.byteenable); end
        tick();
        vectors++; if (av.read !== 1'b0) begin miscompares++; $display("[TB] FAIL rd1_wait_read actual=%0h expected=0", av.read); end
        av.readdata = 32'hDEAD_BEEF; av.readdatavalid = 1'b1;
        vectors++; if (retValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rd1_early_ret actual=%0h expected=0", retValid); end
        tick();
        av.readdata = '0; av.readdatavalid = 1'b0;
        vectors++; if (retValid !== 1'b1 || retData !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd1_ret actual=%0h/%h expected=1/deadbeef", retValid, retData); end
        tick();
        vectors++; if (retValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rd1_ret_pulse actual=%0h expected=0", retValid); end
        vectors++; if (retCount - startCount !== 1) begin miscompares++; $display("[TB] FAIL rd1_count actual=%0d expected=1", retCount - startCount); end
    endtask

    task automatic test_burst_read();
        logic [31:0] expAddr [4] = '{32'h2004, 32'h2008, 32'h200C, 32'h2010};
        logic [31:0] beatData [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
        int startCount;
        startCount = retCount;
        l1Addr = 32'h0000_2004; l1Rnw = 1'b1; l1Size = 3'd3; l1Request = 1'b1;
        #1;
        vectors++; if (l1Ack !== 1'b1) begin miscompares++; $display("[TB] FAIL rd4_ack actual=%0h expected=1", l1Ack); end
        tick();
        l1Request = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == 1) begin
                av.waitrequest = 1'b1;
                for (int s = 0; s < 2; s++) begin
                    vectors++; if (av.read !== 1'b1 || av.addr !== expAddr[b]) begin miscompares++; $display("[TB] FAIL rd4_stall%0d actual=%0h/%h expected=1/%h", s, av.read, av.addr, expAddr[b]); end
                    tick();
                end
                av.waitrequest = 1'b0;
            end
            vectors++; if (av.read !== 1'b1 || av.addr !== expAddr[b]) begin miscompares++; $display("[TB] FAIL rd4_issue%0d actual=%0h/%h expected=1/%h", b, av.read, av.addr, expAddr[b]); end
            tick();
            vectors++; if (av.read !== 1'b0 || retValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rd4_wait%0d actual=%0h/%0h expected=0/0", b, av.read, retValid); end
            av.readdata = beatData[b]; av.readdatavalid = 1'b1;
            tick();
            av.readdata = '0; av.readdatavalid = 1'b0;
            vectors++; if (retValid !== 1'b1 || retData !== beatData[b]) begin miscompares++; $display("[TB] FAIL rd4_ret%0d actual=%0h/%h expected=1/%h", b, retValid, retData, beatData[b]); end
        end
        tick();
        vectors++; if (retValid !== 1'b0 || av.read !== 1'b0) begin miscompares++; $display("[TB] FAIL rd4_done actual=%0h/%0h expected=0/0", retValid, av.read); end
        vectors++; if (retCount - startCount !== 4) begin miscompares++; $display("[TB] FAIL rd4_count actual=%0d expected=4", retCount - startCount); end
    endtask

    task automatic test_write();
        l1Addr = 32'h0000_3003; l1Data = 32'h1122_3344; l1Be = 4'b1001; l1Rnw = 1'b0; l1Size = 3'd5; l1Request = 1'b1;
        #1;
        vectors++; if (l1Ack !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_ack actual=%0h expected=1", l1Ack); end
        tick();
        l1Request = 1'b0;
        vectors++; if (av.write !== 1'b1 || av.read !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_issue actual=%0h/%0h expected=1/0", av.write, av.read); end
        vectors++; if (av.addr !== 32'h0000_3000 || av.byteenable !== 4'b1001) begin miscompares++; $display("[TB] FAIL wr_addr_be actual=%h/%b expected=00003000/1001", av.addr, av.byteenable); end
        vectors++; if (av.writedata !== 32'h1122_3344) begin miscompares++; $display("[TB] FAIL wr_data actual=%h expected=11223344", av.writedata); end
        tick();
        l1Rnw = 1'b1; l1Addr = 32'h0000_3100; l1Request = 1'b1;
        #1;
        vectors++; if (av.write !== 1'b0 || l1Ack !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_resp_wait1 actual=%0h/%0h expected=0/0", av.write, l1Ack); end
        tick();
        av.writeresponsevalid = 1'b1;
        #1;
        vectors++; if (l1Ack !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_resp_wait2 actual=%0h expected=0", l1Ack); end
        tick();
        av.writeresponsevalid = 1'b0;
        #1;
        vectors++; if (l1Ack !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_idle_ack actual=%0h expected=1", l1Ack); end
        l1Request = 1'b0;
        tick();
    endtask

    task automatic test_write_stall();
        l1Addr = 32'h0000_3ABC; l1Data = 32'hCAFE_F00D; l1Be = 4'b1100; l1Rnw = 1'b0; l1Request = 1'b1;
        tick();
        l1Request = 1'b0;
        av.waitrequest = 1'b1;
        tick();
        vectors++; if (av.write !== 1'b1 || av.addr !== 32'h0000_3ABC || av.byteenable !== 4'b0011) begin miscompares++; $display("[TB] FAIL wrs_held actual=%0h/%h/%b expected=1/00003abc/0011", av.write, av.addr, av.byteenable); end
        vectors++; if (av.writedata !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL wrs_data actual=%h expected=cafef00d", av.writedata); end
        av.waitrequest = 1'b0;
        tick();
        vectors++; if (av.write !== 1'b0) begin miscompares++; $display("[TB] FAIL wrs_release actual=%0h expected=0", av.write); end
        av.writeresponsevalid = 1'b1;
        tick();
        av.writeresponsevalid = 1'b0;
        l1Request = 1'b1; l1Rnw = 1'b1;
        #1;
        vectors++; if (l1Ack !== 1'b1) begin miscompares++; $display("[TB] FAIL wrs_idle actual=%0h expected=1", l1Ack); end
        l1Request = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] expAddr [2] = '{32'h4000, 32'h4004};
        l1Addr = 32'h0000_4000; l1Rnw = 1'b1; l1Size = 3'd1; l1Request = 1'b1;
        #1;
        vectors++; if (l1Ack !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ack0 actual=%0h expected=1", l1Ack); end
        tick();
        for (int b = 0; b < 2; b++) begin
            vectors++; if (l1Ack !== 1'b0 || av.addr !== expAddr[b]) begin miscompares++; $display("[TB] FAIL b2b_issue%0d actual=%0h/%h expected=0/%h", b, l1Ack, av.addr, expAddr[b]); end
            tick();
            av.readdata = 32'h0B0B_0000 + 32'(b); av.readdatavalid = 1'b1;
            #1;
            vectors++; if (l1Ack !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_return%0d actual=%0h expected=0", b, l1Ack); end
            tick();
            av.readdata = '0; av.readdatavalid = 1'b0;
        end
        #1;
        vectors++; if (l1Ack !== 1'b1 || retValid !== 1'b1 || retData !== 32'h0B0B_0001) begin miscompares++; $display("[TB] FAIL b2b_reack actual=%0h/%0h/%h expected=1/1/0b0b0001", l1Ack, retValid, retData); end
        l1Request = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int startCount;
        l1Addr = 32'h0000_5000; l1Rnw = 1'b1; l1Size = 3'd3; l1Request = 1'b1;
        tick();
        l1Request = 1'b0;
        for (int b = 0; b < 2; b++) begin
            tick();
            av.readdata = 32'h5555_0000 + 32'(b); av.readdatavalid = 1'b1;
            tick();
            av.readdata = '0; av.readdatavalid = 1'b0;
        end
        vectors++; if (av.read !== 1'b1 || av.addr !== 32'h0000_5008) begin miscompares++; $display("[TB] FAIL rstm_beat2 actual=%0h/%h expected=1/00005008", av.read, av.addr); end
        tick();
        rst_n = 1'b0; l1Request = 1'b1;
        tick();
        vectors++; if (av.read !== 1'b0 || av.write !== 1'b0 || av.addr !== 32'h0 || av.byteenable !== 4'h0) begin miscompares++; $display("[TB] FAIL rstm_bus actual=%0h/%0h/%h/%h expected=0/0/0/0", av.read, av.write, av.addr, av.byteenable); end
        vectors++; if (retValid !== 1'b0 || retData !== 32'h0 || l1Ack !== 1'b0) begin miscompares++; $display("[TB] FAIL rstm_ret actual=%0h/%h/%0h expected=0/0/0", retValid, retData, l1Ack); end
        startCount = retCount;
        rst_n = 1'b1; l1Request = 1'b0;
        av.readdata = 32'h0BAD_0BAD; av.readdatavalid = 1'b1;
        tick();
        av.readdata = '0; av.readdatavalid = 1'b0;
        tick();
        vectors++; if (retValid !== 1'b0 || retCount - startCount !== 0) begin miscompares++; $display("[TB] FAIL rstm_late actual=%0h/%0d expected=0/0", retValid, retCount - startCount); end
        l1Request = 1'b1;
        #1;
        vectors++; if (l1Ack !== 1'b1 || av.read !== 1'b0) begin miscompares++; $display("[TB] FAIL rstm_idle actual=%0h/%0h expected=1/0", l1Ack, av.read); end
        l1Request = 1'b0;
        tick();
    endtask

    task automatic test_addr_wrap();
        l1Addr = 32'hFFFF_FFFC; l1Rnw = 1'b1; l1Size = 3'd1; l1Request = 1'b1;
        tick();
        l1Request = 1'b0;
        vectors++; if (av.addr !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap_beat0 actual=%h expected=fffffffc", av.addr); end
        tick();
        av.readdata = 32'h7777_0000; av.readdatavalid = 1'b1;
        tick();
        av.readdatavalid = 1'b0;
        vectors++; if (av.read !== 1'b1 || av.addr !== 32'h0000_0000) begin miscompares++; $display("[TB] FAIL wrap_beat1 actual=%0h/%h expected=1/00000000", av.read, av.addr); end
        tick();
        av.readdata = 32'h7777_0001; av.readdatavalid = 1'b1;
        tick();
        av.readdata = '0; av.readdatavalid = 1'b0;
        vectors++; if (retValid !== 1'b1 || retData !== 32'h7777_0001) begin miscompares++; $display("[TB] FAIL wrap_ret actual=%0h/%h expected=1/77770001", retValid, retData); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst_read();
        test_write();
        test_write_stall();
        test_back_to_back();
        test_reset_mid_burst();
        test_addr_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
